// File: rtl/regfile_param.sv
// Two-read/one-write register file with per-entry valid bits and a DEPTH-cycle
// synchronous clear sweep; optional same-cycle write bypass and hardwired-zero entry 0.
module regfile_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [AW-1:0]    wsel,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    rsel_a,
   input  logic [AW-1:0]    rsel_b,
   output logic [WIDTH-1:0] qa,
   output logic [WIDTH-1:0] qb,
   output logic             va,
   output logic             vb,
   input  logic             init,
   output logic             busy
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                        state_q, state_d;
   logic [AW-1:0]                 ptr_q, ptr_d;
   logic                          busy_q, busy_d;
   logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
   logic [DEPTH-1:0]              vld_q, vld_d;
   logic                          wr_commit;

   // A write only commits in IDLE without a competing init; bypass uses the same
   // qualifier so forwarded data always matches what lands in storage.
   assign wr_commit = clr_n && en && !init && (state_q == IDLE) &&
                      !((ZERO_REG != 0) && (wsel == '0));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_d   = mem_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: begin
            if (init) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end else if (wr_commit) begin
               mem_d[wsel] = d;
               vld_d[wsel] = 1'b1;
            end
         end
         SWEEP: begin
            mem_d[ptr_q] = '0;
            vld_d[ptr_q] = 1'b0;
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SWEEP);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         mem_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         mem_q   <= mem_d;
         vld_q   <= vld_d;
      end
   end

   assign busy = busy_q;

   // Returns {valid, data} for one read port.
   function automatic logic [WIDTH:0] rd_port(input logic [AW-1:0] sel);
      if ((ZERO_REG != 0) && (sel == '0))
         return {1'b1, {WIDTH{1'b0}}};
      else if ((BYPASS != 0) && wr_commit && (sel == wsel))
         return {1'b1, d};
      else
         return {vld_q[sel], mem_q[sel]};
   endfunction

   always_comb begin
      {va, qa} = rd_port(rsel_a);
      {vb, qb} = rd_port(rsel_b);
   end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry, 1..64.
REQ-002 Parameter DEPTH, default 8: entry count, power of two, 2..256; AW = log2(DEPTH).
REQ-003 Parameter BYPASS, default 0: 1 forwards same-cycle write data to a matching read port.
REQ-004 Parameter ZERO_REG, default 0: 1 hardwires entry 0 to zero, with valid always 1.
REQ-005 clk  in  1  single clock, rising edge active.
REQ-006 clr_n  in  1  reset, asynchronous assert, active-low; all storage and state clear while low.
REQ-007 en  in  1  write enable, sampled on the rising clk edge.
REQ-008 wsel  in  AW  write address.
REQ-009 d  in  WIDTH  write data.
REQ-010 rsel_a, rsel_b  in  AW each  read addresses, ports A and B.
REQ-011 qa, qb  out  WIDTH each  read data, combinational from rsel_x.
REQ-012 va, vb  out  1 each  entry-written-since-clear flag for the addressed entry.
REQ-013 init  in  1  request to start a synchronous clear sweep.
REQ-014 busy  out  1  high while the sweep runs.

Function
REQ-015 Each entry SHALL hold WIDTH data bits plus one valid bit.
REQ-016 If en=1 and state is IDLE, entry[wsel] SHALL take d and its valid bit SHALL go to 1 at the clk edge.
REQ-017 With BYPASS=0, qa/qb SHALL show the newly written value starting in the cycle after the write edge.
REQ-018 With BYPASS=1, if en=1, state is IDLE, and rsel_x==wsel, then qx SHALL equal d and vx SHALL be 1 in the same cycle.
REQ-019 With ZERO_REG=1, writes to entry 0 SHALL be dropped. Reads of entry 0 SHALL return 0 with valid 1, and bypass SHALL not apply to entry 0.
REQ-020 Both read ports SHALL be independent. Equal rsel_a and rsel_b SHALL return identical data.
REQ-021 The sweep FSM SHALL have two states: IDLE and SWEEP.
REQ-022 IDLE -> SWEEP SHALL occur on the edge where init=1. That edge SHALL also load the pointer with 0.
REQ-023 In SWEEP, each edge SHALL clear entry[ptr], setting data to 0 and valid to 0, then increment ptr.
REQ-024 SWEEP -> IDLE SHALL occur on the edge that clears entry DEPTH-1, so the sweep lasts exactly DEPTH cycles.
REQ-025 busy SHALL equal (state==SWEEP) and SHALL be registered.
REQ-026 If init=1 and en=1 on the same edge in IDLE, init SHALL win and the write SHALL be dropped.
REQ-027 en and init SHALL be ignored while busy=1; no restart and no queuing.
REQ-028 Reads during SWEEP SHALL return current storage, which mixes cleared and not-yet-cleared entries.
REQ-029 The pointer SHALL be AW bits wide with no wrap past DEPTH-1.

Reset
REQ-030 While clr_n=0, regardless of clk, the block SHALL force:
- all entry data to 0 and all valid bits to 0;
- state to IDLE, ptr to 0, busy to 0.
REQ-031 qa/qb SHALL read 0 and va/vb SHALL read 0 during reset, except entry 0 when ZERO_REG=1, which reads valid 1.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep immediately. After release the block SHALL be IDLE and fully cleared.
REQ-033 Release SHALL be synchronous-safe: the first write SHALL take effect on the first rising edge after clr_n goes high.

Verification (WIDTH=8, DEPTH=8, BYPASS=0 unless stated)
REQ-034 Write d=8'hFF-i to wsel=i for i=0..7, then read rsel_a=i, rsel_b=7-i. Expect:
- qa=8'hFF-i and qb=8'hF8+i;
- va=vb=1.
REQ-035 After REQ-034, pulse init for one cycle. Expect:
- busy=1 for exactly 8 cycles;
- a write of 8'h55 to entry 3 during the sweep is dropped;
- afterwards all entries read 0 with valid 0.
REQ-036 BYPASS=1: en=1, wsel=5, d=8'hA5, rsel_a=5. Expect qa=8'hA5 and va=1 in the same cycle; rsel_b=4 is unaffected.
REQ-037 ZERO_REG=1: write 8'h77 to entry 0. Expect qa=0 and va=1 both before and after the write.
REQ-038 Assert clr_n=0 asynchronously between clk edges during a sweep at ptr=4. Expect immediately:
- busy=0;
- all reads 0 with valid 0;
- a write after release succeeds next edge.
REQ-039 init=1 and en=1 (wsel=2, d=8'h3C) on the same edge in IDLE. Expect:
- the sweep starts;
- entry 2 reads 0 with valid 0 after the sweep.
